phi_clock_divider: RTL and testbench

Parametrised successor to the fixed divide-by-6 PHI0/M2 generator. Divides the master clock into the core's PHI0 and the external M2 strobe. It adds two selectable divide/duty profiles (mode 0 / mode 1, e.g. NTSC/PAL) that switch glitch-free at period boundaries, a halt handshake that parks the clock cleanly at end of period, and a per-period strobe. It sits between the clock pad and the embedded 6502 core.

---
 rtl/phi_clock_divider.sv | 118 +++++++++++
 tb/tb_phi_clock_divider.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/phi_clock_divider.sv
// PHI0/M2 clock divider with two selectable divide/duty profiles and halt handshake.
// All outputs except M2_topad come straight from flops decoded off the next count.
module phi_clock_divider #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned DIV0  = 6,
  parameter int unsigned LOW0  = 3,
  parameter int unsigned M2R0  = 2,
  parameter int unsigned DIV1  = 8,
  parameter int unsigned LOW1  = 4,
  parameter int unsigned M2R1  = 3
) (
  input  logic CLK,
  input  logic n_RES,
  input  logic MODE,
  input  logic HALT,
  input  logic PHI2_fromcore,
  output logic PHI0_tocore,
  output logic M2_topad,
  output logic PERIOD,
  output logic HALTED
);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t LAST0 = cnt_t'(DIV0 - 1);
  localparam cnt_t LOWC0 = cnt_t'(LOW0);
  localparam cnt_t M2RC0 = cnt_t'(M2R0);
  localparam cnt_t LAST1 = cnt_t'(DIV1 - 1);
  localparam cnt_t LOWC1 = cnt_t'(LOW1);
  localparam cnt_t M2RC1 = cnt_t'(M2R1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STOP,
    ST_PARK
  } state_t;

  state_t state, state_next;
  cnt_t   cnt, cnt_next;
  cnt_t   last_r, low_r, m2r_r;
  cnt_t   last_next, low_next, m2r_next;
  cnt_t   sel_last, sel_low, sel_m2r;
  logic   wrap, reload;
  logic   phi0_r, m2e_r, per_r, halted_r;
  logic   phi0_next, m2e_next, per_next;

  always_comb begin
    sel_last = MODE ? LAST1 : LAST0;
    sel_low  = MODE ? LOWC1 : LOWC0;
    sel_m2r  = MODE ? M2RC1 : M2RC0;
  end

  always_comb begin
    state_next = state;
    wrap       = (cnt == last_r);
    reload     = wrap;
    cnt_next   = wrap ? '0 : cnt + cnt_t'(1);

    unique case (state)
      ST_RUN: begin
        if (HALT) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (wrap)       state_next = HALT ? ST_PARK : ST_RUN;
        else if (!HALT) state_next = ST_RUN;
      end
      ST_PARK: begin
        // Release from park mimics the first edge after reset: reload and step to 1.
        reload   = 1'b0;
        cnt_next = '0;
        if (!HALT) begin
          state_next = ST_RUN;
          reload     = 1'b1;
          cnt_next   = cnt_t'(1);
        end
      end
      default: state_next = ST_RUN;
    endcase

    last_next = reload ? sel_last : last_r;
    low_next  = reload ? sel_low  : low_r;
    m2r_next  = reload ? sel_m2r  : m2r_r;

    phi0_next = (state_next != ST_PARK) && (cnt_next >= low_next);
    m2e_next  = (state_next != ST_PARK) && (cnt_next >= m2r_next);
    per_next  = (state_next != ST_PARK) && (cnt_next == '0);
  end

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      state    <= ST_RUN;
      cnt      <= '0;
      last_r   <= sel_last;
      low_r    <= sel_low;
      m2r_r    <= sel_m2r;
      phi0_r   <= 1'b0;
      m2e_r    <= 1'b0;
      per_r    <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      last_r   <= last_next;
      low_r    <= low_next;
      m2r_r    <= m2r_next;
      phi0_r   <= phi0_next;
      m2e_r    <= m2e_next;
      per_r    <= per_next;
      halted_r <= (state_next == ST_PARK);
    end
  end

  assign PHI0_tocore = phi0_r;
  assign M2_topad    = (m2e_r | PHI2_fromcore) & n_RES;
  assign PERIOD      = per_r;
  assign HALTED      = halted_r;

endmodule

// File: tb/tb_phi_clock_divider.sv
// Directed bench for phi_clock_divider: profiles, mode switch, halt handshake, async reset.
module tb_phi_clock_divider;

  logic CLK = 1'b0;
  logic n_RES = 1'b0;
  logic MODE = 1'b0;
  logic HALT = 1'b0;
  logic PHI2_fromcore = 1'b0;
  logic PHI0_tocore, M2_topad, PERIOD, HALTED;

  int checks = 0;
  int errors = 0;

  // Per-count expected levels, indexed by the counter value after the edge.
  logic phi_m0 [6] = '{0, 0, 0, 1, 1, 1};
  logic m2_m0  [6] = '{0, 0, 1, 1, 1, 1};
  logic phi_m1 [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  logic m2_m1  [8] = '{0, 0, 0, 1, 1, 1, 1, 1};

  phi_clock_divider #(
    .CNT_W(4), .DIV0(6), .LOW0(3), .M2R0(2), .DIV1(8), .LOW1(4), .M2R1(3)
  ) dut (
    .CLK(CLK),
    .n_RES(n_RES),
    .MODE(MODE),
    .HALT(HALT),
    .PHI2_fromcore(PHI2_fromcore),
    .PHI0_tocore(PHI0_tocore),
    .M2_topad(M2_topad),
    .PERIOD(PERIOD),
    .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic phi, input logic m2,
                            input logic per, input logic hlt);
    check({tag, ".phi0"},   int'(PHI0_tocore), int'(phi));
    check({tag, ".m2"},     int'(M2_topad),    int'(m2));
    check({tag, ".period"}, int'(PERIOD),      int'(per));
    check({tag, ".halted"}, int'(HALTED),      int'(hlt));
  endtask

  task automatic do_reset(input logic mode);
    @(negedge CLK);
    MODE  = mode;
    HALT  = 1'b0;
    PHI2_fromcore = 1'b0;
    n_RES = 1'b0;
    #2;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    n_RES = 1'b1;
  endtask

  initial begin
    // Mode 0 free-running for 20 edges.
    do_reset(1'b0);
    for (int e = 1; e <= 20; e++) begin
      tick();
      check_outs($sformatf("m0_e%0d", e), phi_m0[e % 6], m2_m0[e % 6],
                 (e % 6) == 0, 1'b0);
    end

    // Switch to mode 1 mid-period: first period stays 6, then 8-cycle periods.
    do_reset(1'b0);
    for (int e = 1; e <= 22; e++) begin
      tick();
      if (e == 4) MODE = 1'b1;
      if (e <= 6)
        check_outs($sformatf("sw_e%0d", e), phi_m0[e % 6], m2_m0[e % 6], e == 6, 1'b0);
      else
        check_outs($sformatf("sw_e%0d", e), phi_m1[(e - 6) % 8], m2_m1[(e - 6) % 8],
                   ((e - 6) % 8) == 0, 1'b0);
    end

    // Held HALT parks at the first wrap; release restarts as after reset.
    do_reset(1'b0);
    tick();
    tick();
    HALT = 1'b1;
    for (int e = 3; e <= 5; e++) begin
      tick();
      check_outs($sformatf("hlt_e%0d", e), phi_m0[e], m2_m0[e], 1'b0, 1'b0);
    end
    tick();
    check_outs("hlt_park", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_outs("hlt_hold", 1'b0, 1'b0, 1'b0, 1'b1);
    HALT = 1'b0;
    tick();
    check_outs("rel_e1", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("rel_e2", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check_outs("rel_e3", 1'b1, 1'b1, 1'b0, 1'b0);

    // HALT pulse dropped before the wrap: no interruption.
    do_reset(1'b0);
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 2) HALT = 1'b1;
      if (e == 4) HALT = 1'b0;
      check_outs($sformatf("pulse_e%0d", e), phi_m0[e % 6], m2_m0[e % 6],
                 (e % 6) == 0, 1'b0);
    end

    // M2 follows core PHI2 combinationally; reset forces outputs low with no edge.
    do_reset(1'b0);
    tick();
    PHI2_fromcore = 1'b1;
    #1;
    check("phi2_stretch.m2", int'(M2_topad), 1);
    check("phi2_stretch.phi0", int'(PHI0_tocore), 0);
    tick();
    tick();
    tick();
    check("pre_rst.phi0", int'(PHI0_tocore), 1);
    #1;
    n_RES = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset at cnt=4 in mode 1 with MODE now 0: restart uses mode 0.
    do_reset(1'b1);
    for (int e = 1; e <= 4; e++) begin
      tick();
      check_outs($sformatf("m1_e%0d", e), phi_m1[e], m2_m1[e], 1'b0, 1'b0);
    end
    MODE = 1'b0;
    #2;
    n_RES = 1'b0;
    #2;
    check_outs("m1_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    n_RES = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check_outs($sformatf("rst_m0_e%0d", e), phi_m0[e % 6], m2_m0[e % 6],
                 (e % 6) == 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
